z_result_buffer: RTL and testbench
==================================

// Module: z_result_buffer
// PURPOSE
//  Downstream of the ALU datapath (rotate/shift/add/mul units). Captures each
//  ALU result into a small FIFO, then returns it over the shared 32-bit bus
//  as Zlow and, for 64-bit results, Zhigh.
//  Bus access uses a request/grant handshake, so the ALU can issue the next
//  operation while an earlier result is still waiting for the bus.
// PARAMETERS
//  DATA_W  32  width of one bus word (Zlow/Zhigh each DATA_W bits)
//  DEPTH   2   FIFO entries; power of two, >=2
// PORTS
//  clock        in   1        single clock, all state updates on rising edge
//  clear        in   1        synchronous reset, active-low; sampled on rising edge of clock
//  in_valid     in   1        ALU result present this cycle
//  in_ready     out  1        buffer can accept (not full)
//  in_lo        in   DATA_W   result low word (rotate/shift result)
//  in_hi        in   DATA_W   result high word (mul/div only)
//  in_wide      in   1        1 = send hi word after lo word
//  bus_req      out  1        requesting bus to drive a word
//  bus_grant    in   1        bus arbiter grant
//  bus_out      out  DATA_W   word driven to bus
//  bus_sel_hi   out  1        0 = bus_out is Zlow, 1 = Zhigh
//  count        out  $clog2(DEPTH)+1  entries held, including one in transfer
//  overflow     out  1        sticky: in_valid seen while in_ready=0
// BEHAVIOUR
//  - Reset (clear=0 at edge): FIFO emptied, pointers 0, state IDLE.
//    Outputs after reset: count=0, in_ready=1, bus_req=0, bus_out=0,
//    bus_sel_hi=0, overflow=0.
//    A reset during a transfer discards all entries, including half-sent wide ones.
//  - Push: accepted at an edge where in_valid & in_ready. Stores {in_wide,in_hi,in_lo}.
//    in_ready = (count<DEPTH), combinational from registered count. No pass-through when full.
//  - FSM, registered, states IDLE / SEND_LO / SEND_HI:
//    IDLE -> SEND_LO at the edge where the FIFO is non-empty. bus_req rises
//    the cycle after the first push, so latency is 1 cycle.
//    SEND_LO: bus_req=1, bus_out=head.lo, bus_sel_hi=0. On edge with bus_grant=1:
//      if head.wide -> SEND_HI; otherwise pop head, then go to SEND_LO if entries
//      remain, else IDLE.
//    SEND_HI: bus_req=1, bus_out=head.hi, bus_sel_hi=1. On edge with bus_grant=1:
//      pop head, then go to SEND_LO if entries remain, else IDLE.
//    bus_grant=0 -> hold state; bus_out stays stable.
//  - In IDLE: bus_out=0 and bus_sel_hi=0. A grant that arrives without a request is ignored.
//  - Simultaneous push and pop in one edge: both occur; count unchanged.
//  - Pointer wrap at DEPTH is modulo; count is the only source for full/empty.
//  - Push while full: entry dropped, FIFO unchanged, overflow set to 1 until reset.
//  - Back-to-back transfers: with grant held high, one word transfers per cycle
//    and there is no idle cycle between entries.
// TESTING
//  1 Reset: hold clear=0 for 2 cycles with in_valid=1 -> count=0, bus_req=0,
//    overflow=0, in_ready=1.
//  2 Narrow result: push lo=32'h8000_0001 with wide=0, grant tied 1 ->
//    next cycle bus_req=1, bus_out=8000_0001, sel_hi=0; following cycle IDLE, count=0.
//  3 Wide result: push lo=32'h0000_0004, hi=32'h0000_0003, wide=1, grant=1 ->
//    two consecutive cycles: bus_out 0000_0004 (sel_hi=0), then 0000_0003 (sel_hi=1).
//  4 Full/overflow: grant=0, push 3 entries -> first two accepted, count=2,
//    in_ready=0, overflow=1. Then grant=1 -> only the first two entries appear,
//    in order.
//  5 Simultaneous: count=1 in SEND_LO, push and grant in the same edge ->
//    count stays 1, the new entry is sent next cycle.
//  6 Reset mid-transfer: in SEND_HI with 2 entries, pulse clear=0 ->
//    IDLE, count=0, no further bus_req.

Source files
------------

// File: rtl/z_result_buffer.sv
// ALU result buffer: queues {wide,hi,lo} results and returns them over the shared bus as Zlow then Zhigh.
// Latency: bus_req rises the cycle after a push into an empty buffer; one word per granted cycle.
// Backpressure: in_ready drops when DEPTH entries are held; a push while full is dropped and sets sticky overflow.
module z_result_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_lo,
   input  logic [DATA_W-1:0]        in_hi,
   input  logic                     in_wide,
   output logic                     bus_req,
   input  logic                     bus_grant,
   output logic [DATA_W-1:0]        bus_out,
   output logic                     bus_sel_hi,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

   state_t              state;
   state_t              state_nxt;

   logic [DATA_W-1:0]   mem_lo   [DEPTH];
   logic [DATA_W-1:0]   mem_hi   [DEPTH];
   logic                mem_wide [DEPTH];

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       rd_ptr_nxt;

   logic                push;
   logic                pop;
   logic [CW-1:0]       remain;
   logic [CW-1:0]       count_nxt;
   logic [DATA_W-1:0]   nhead_lo;
   logic [DATA_W-1:0]   nhead_hi;

   // Full/empty come only from the registered count, so in_ready never depends on this cycle's pop.
   assign in_ready = (count < DEPTH_C);

   // Handshake decode, next occupancy, and the entry that will be at the head after this edge.
   always_comb begin
      push       = in_valid & in_ready;
      pop        = bus_grant & (((state == SEND_LO) & ~mem_wide[rd_ptr]) | (state == SEND_HI));
      remain     = count - CW'(pop);
      count_nxt  = remain + CW'(push);
      rd_ptr_nxt = rd_ptr + AW'(pop);
      // When the buffer drains to nothing this edge, the incoming entry becomes the head
      // before it is visible in the storage array, so forward it directly.
      if (push && (remain == '0)) begin
         nhead_lo = in_lo;
         nhead_hi = in_hi;
      end else begin
         nhead_lo = mem_lo[rd_ptr_nxt];
         nhead_hi = mem_hi[rd_ptr_nxt];
      end
   end

   // Next-state decision; a grant only matters while a word is being offered.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (count_nxt != '0) state_nxt = SEND_LO;
         end
         SEND_LO: begin
            if (bus_grant) begin
               if (mem_wide[rd_ptr])       state_nxt = SEND_HI;
               else if (count_nxt != '0)   state_nxt = SEND_LO;
               else                        state_nxt = IDLE;
            end
         end
         SEND_HI: begin
            if (bus_grant) state_nxt = (count_nxt != '0) ? SEND_LO : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Entry storage; contents are don't-care until written, occupancy is tracked by count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_lo[wr_ptr]   <= in_lo;
         mem_hi[wr_ptr]   <= in_hi;
         mem_wide[wr_ptr] <= in_wide;
      end
   end

   // FSM, pointers, occupancy and registered bus outputs derived from the next state and next head.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         bus_req    <= 1'b0;
         bus_out    <= '0;
         bus_sel_hi <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         rd_ptr <= rd_ptr_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (in_valid && !in_ready) overflow <= 1'b1;
         case (state_nxt)
            SEND_LO: begin
               bus_req    <= 1'b1;
               bus_out    <= nhead_lo;
               bus_sel_hi <= 1'b0;
            end
            SEND_HI: begin
               bus_req    <= 1'b1;
               bus_out    <= nhead_hi;
               bus_sel_hi <= 1'b1;
            end
            default: begin
               bus_req    <= 1'b0;
               bus_out    <= '0;
               bus_sel_hi <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z_result_buffer.sv
// Bench for z_result_buffer: directed scenarios followed by random traffic against a queue model.
// Model: held entries form a queue; while non-empty the head's current word is offered on the bus.
// Each granted cycle sends one word; a wide entry leaves after its second word.
module tb_z_result_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic                  clock;
   logic                  clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_lo;
   logic [DATA_W-1:0]     in_hi;
   logic                  in_wide;
   logic                  bus_req;
   logic                  bus_grant;
   logic [DATA_W-1:0]     bus_out;
   logic                  bus_sel_hi;
   logic [$clog2(DEPTH):0] count;
   logic                  overflow;

   z_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_lo      (in_lo),
      .in_hi      (in_hi),
      .in_wide    (in_wide),
      .bus_req    (bus_req),
      .bus_grant  (bus_grant),
      .bus_out    (bus_out),
      .bus_sel_hi (bus_sel_hi),
      .count      (count),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic              wide;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } ent_t;

   ent_t q[$];
   bit   lo_sent;
   bit   m_ovf;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check in_ready before the edge, advance the model, check after the edge.
   task automatic cyc(input logic v, input logic w, input logic [31:0] lo, input logic [31:0] hi,
                      input logic g, input logic clr);
      ent_t e;
      bit   rdy;
      logic [31:0] exp_out;
      @(negedge clock);
      in_valid  = v;
      in_wide   = w;
      in_lo     = lo;
      in_hi     = hi;
      bus_grant = g;
      clear     = clr;
      #1;
      rdy = (q.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clock);
      if (!clr) begin
         q.delete();
         lo_sent = 0;
         m_ovf   = 0;
      end else begin
         if (v && !rdy) m_ovf = 1;
         if (g && q.size() > 0) begin
            if (q[0].wide && !lo_sent) lo_sent = 1;
            else begin
               void'(q.pop_front());
               lo_sent = 0;
            end
         end
         if (v && rdy) begin
            e.wide = w;
            e.hi   = hi;
            e.lo   = lo;
            q.push_back(e);
         end
      end
      #1;
      if (q.size() == 0) exp_out = 32'h0;
      else exp_out = lo_sent ? q[0].hi : q[0].lo;
      chk("count",      32'(count),      32'(q.size()));
      chk("bus_req",    32'(bus_req),    32'(q.size() > 0));
      chk("bus_sel_hi", 32'(bus_sel_hi), 32'(lo_sent));
      chk("bus_out",    bus_out,         exp_out);
      chk("overflow",   32'(overflow),   32'(m_ovf));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      lo_sent  = 0;
      m_ovf    = 0;
      clear     = 1'b0;
      in_valid  = 1'b1;
      in_wide   = 1'b0;
      in_lo     = '0;
      in_hi     = '0;
      bus_grant = 1'b0;

      // Reset held with in_valid asserted
      cyc(1, 0, 32'h1111_1111, 32'h0, 1, 0);
      cyc(1, 0, 32'h2222_2222, 32'h0, 1, 0);
      chk("t1_count",    32'(count),    32'd0);
      chk("t1_bus_req",  32'(bus_req),  32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_in_ready", 32'(in_ready), 32'd1);

      // Narrow result, grant tied high
      cyc(1, 0, 32'h8000_0001, 32'hdead_beef, 1, 1);
      chk("t2_req",  32'(bus_req),    32'd1);
      chk("t2_out",  bus_out,         32'h8000_0001);
      chk("t2_sel",  32'(bus_sel_hi), 32'd0);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t2_idle_req", 32'(bus_req), 32'd0);
      chk("t2_count",    32'(count),   32'd0);

      // Wide result: lo word then hi word on consecutive cycles
      cyc(1, 1, 32'h0000_0004, 32'h0000_0003, 1, 1);
      chk("t3_lo",     bus_out,         32'h0000_0004);
      chk("t3_lo_sel", 32'(bus_sel_hi), 32'd0);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t3_hi",     bus_out,         32'h0000_0003);
      chk("t3_hi_sel", 32'(bus_sel_hi), 32'd1);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t3_done", 32'(bus_req), 32'd0);

      // Full and overflow: third push dropped, first two drain in order
      cyc(1, 0, 32'haaaa_0001, 32'h0, 0, 1);
      cyc(1, 0, 32'haaaa_0002, 32'h0, 0, 1);
      cyc(1, 0, 32'haaaa_0003, 32'h0, 0, 1);
      chk("t4_count",    32'(count),    32'd2);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_overflow", 32'(overflow), 32'd1);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t4_second", bus_out, 32'haaaa_0002);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t4_drained", 32'(bus_req), 32'd0);

      // Clear overflow, then simultaneous push and pop at count=1
      cyc(0, 0, 32'h0, 32'h0, 0, 0);
      cyc(1, 0, 32'hbbbb_0001, 32'h0, 0, 1);
      cyc(1, 0, 32'hbbbb_0002, 32'h0, 1, 1);
      chk("t5_count", 32'(count), 32'd1);
      chk("t5_next",  bus_out,    32'hbbbb_0002);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);

      // Reset in the middle of a wide transfer with two entries held
      cyc(1, 1, 32'hcccc_0001, 32'hcccc_1001, 0, 1);
      cyc(1, 0, 32'hcccc_0002, 32'h0, 0, 1);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t6_in_hi", 32'(bus_sel_hi), 32'd1);
      chk("t6_cnt2",  32'(count),      32'd2);
      cyc(0, 0, 32'h0, 32'h0, 1, 0);
      chk("t6_count", 32'(count),   32'd0);
      chk("t6_req",   32'(bus_req), 32'd0);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      cyc(0, 0, 32'h0, 32'h0, 1, 1);
      chk("t6_quiet", 32'(bus_req), 32'd0);

      // Random traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 99) < 55),
             1'($urandom_range(0, 1)),
             $urandom, $urandom,
             1'($urandom_range(0, 99) < 60),
             1'($urandom_range(0, 99) >= 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
